// File: rtl/rx_pkg.sv
// Shared constants, FSM state type and helpers for the multi-channel receive frame packer.
package rx_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_OVR    = 3'd2;
  localparam logic [2:0] ADDR_SEQ    = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_FMT = 1;
  localparam int unsigned CTRL_HDR = 2;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_I    = 2'd2,
    ST_Q    = 2'd3
  } state_t;

  // Number of set bits in an 8-bit vector.
  function automatic logic [7:0] popcount8(input logic [7:0] v);
    logic [7:0] n;
    n = 8'd0;
    for (int b = 0; b < 8; b++) n = n + 8'(v[b]);
    return n;
  endfunction

endpackage

// File: rtl/rx_channel_capture.sv
// One receiver channel: holding register, valid flag and overrun detection.
module rx_channel_capture #(
  parameter int unsigned SAMPLE_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cap_en,
  input  logic                clr,
  input  logic                take,
  input  logic                strobe,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [SAMPLE_W-1:0] sample_q,
  output logic [SAMPLE_W-1:0] hold_i,
  output logic [SAMPLE_W-1:0] hold_q,
  output logic                valid,
  output logic                overrun_c
);

  // A strobe coinciding with the packer taking the held sample refills the slot cleanly.
  assign overrun_c = cap_en & strobe & valid & ~take;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_i <= '0;
      hold_q <= '0;
      valid  <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else begin
      if (take) valid <= 1'b0;
      if (cap_en && strobe && (!valid || take)) begin
        hold_i <= sample_i;
        hold_q <= sample_q;
        valid  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_frame_packer.sv
// Captures I/Q from NUM_CH receivers, double-buffers a full frame and serialises it
// (optional header, then I/Q per enabled channel ascending) into a 32-bit FIFO.
module rx_frame_packer
  import rx_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_strobe,
  input  logic [NUM_CH*SAMPLE_W-1:0]   ch_i,
  input  logic [NUM_CH*SAMPLE_W-1:0]   ch_q,
  output logic [31:0]                  fifo_writedata,
  output logic                         fifo_write,
  input  logic                         fifo_full,
  input  logic [2:0]                   ctl_address,
  input  logic                         ctl_read,
  output logic [31:0]                  ctl_readdata,
  input  logic                         ctl_write,
  input  logic [31:0]                  ctl_writedata
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SUM_W = CNT_W + 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]          ctrl;
  logic [NUM_CH-1:0]   mask, frame_mask, valid, take, ovr_hit_c;
  logic                frame_fmt, sticky, enable;
  logic [CNT_W-1:0]    ovr_cnt, ovr_sat_c;
  logic [SUM_W-1:0]    ovr_sum_c;
  logic [7:0]          ovr_n_c;
  logic [15:0]         seq;
  logic                seq_clr_c, start_c, last_c, fmt_c, unused_wd_c;
  logic [SAMPLE_W-1:0] hold_i [NUM_CH];
  logic [SAMPLE_W-1:0] hold_q [NUM_CH];
  logic [SAMPLE_W-1:0] shadow_i [NUM_CH];
  logic [SAMPLE_W-1:0] shadow_q [NUM_CH];
  logic [SAMPLE_W-1:0] samp_c;
  logic [NUM_CH-1:0]   sel_mask_c;
  logic [CH_W-1:0]     ch_idx, idx_nxt, first_ch_c, next_ch_c;
  logic                has_next_c;
  logic [31:0]         word_c, rd_c;
  state_t              state, state_nxt;

  assign enable      = ctrl[CTRL_EN];
  assign take        = start_c ? mask : '0;
  assign unused_wd_c = ^ctl_writedata;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    rx_channel_capture #(.SAMPLE_W(SAMPLE_W)) u_cap (
      .clk       (clk),
      .reset     (reset),
      .cap_en    (enable & mask[k]),
      .clr       (~enable),
      .take      (take[k]),
      .strobe    (ch_strobe[k]),
      .sample_i  (ch_i[k*SAMPLE_W +: SAMPLE_W]),
      .sample_q  (ch_q[k*SAMPLE_W +: SAMPLE_W]),
      .hold_i    (hold_i[k]),
      .hold_q    (hold_q[k]),
      .valid     (valid[k]),
      .overrun_c (ovr_hit_c[k])
    );
  end

  // Lowest enabled channel, and the next enabled channel above the current one.
  always_comb begin
    sel_mask_c = (state == ST_IDLE) ? mask : frame_mask;
    first_ch_c = '0;
    next_ch_c  = '0;
    has_next_c = 1'b0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (sel_mask_c[k]) first_ch_c = CH_W'(k);
      if (frame_mask[k] && (k > int'(ch_idx))) begin
        next_ch_c  = CH_W'(k);
        has_next_c = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = ch_idx;
    last_c     = 1'b0;
    start_c    = (state == ST_IDLE) && enable && (|mask) && ((valid & mask) == mask);
    fifo_write = (state != ST_IDLE) && !fifo_full;
    case (state)
      ST_IDLE: begin
        idx_nxt = first_ch_c;
        if (start_c) state_nxt = ctrl[CTRL_HDR] ? ST_HDR : ST_I;
      end
      ST_HDR: if (fifo_write) begin
        state_nxt = ST_I;
        idx_nxt   = first_ch_c;
      end
      ST_I: if (fifo_write) state_nxt = ST_Q;
      ST_Q: if (fifo_write) begin
        if (has_next_c) begin
          state_nxt = ST_I;
          idx_nxt   = next_ch_c;
        end else begin
          state_nxt = ST_IDLE;
          last_c    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Word for the state being entered; at frame start the shadow copy is not yet loaded.
  always_comb begin
    fmt_c = (state == ST_IDLE) ? ctrl[CTRL_FMT] : frame_fmt;
    if (state == ST_IDLE) samp_c = (state_nxt == ST_Q) ? hold_q[idx_nxt] : hold_i[idx_nxt];
    else                  samp_c = (state_nxt == ST_Q) ? shadow_q[idx_nxt] : shadow_i[idx_nxt];
    if (state_nxt == ST_HDR) word_c = {HDR_MAGIC, popcount8(8'(sel_mask_c)), seq};
    else if (fmt_c)          word_c = 32'(samp_c) << (32 - SAMPLE_W);
    else                     word_c = 32'($signed(samp_c));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      ch_idx         <= '0;
      fifo_writedata <= '0;
      frame_mask     <= '0;
      frame_fmt      <= 1'b0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
        shadow_i[k] <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state  <= state_nxt;
      ch_idx <= idx_nxt;
      if (start_c || (fifo_write && (state_nxt != ST_IDLE))) fifo_writedata <= word_c;
      if (start_c) begin
        frame_mask <= mask;
        frame_fmt  <= ctrl[CTRL_FMT];
        for (int k = 0; k < int'(NUM_CH); k++) begin
          shadow_i[k] <= hold_i[k];
          shadow_q[k] <= hold_q[k];
        end
      end
    end
  end

  // Overrun accounting: one count per overrunning channel, saturating.
  always_comb begin
    ovr_n_c   = popcount8(8'(ovr_hit_c));
    ovr_sum_c = SUM_W'(ovr_cnt) + SUM_W'(ovr_n_c);
    ovr_sat_c = (ovr_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(ovr_sum_c);
    seq_clr_c = ctl_write && (ctl_address == ADDR_CTRL) && ctl_writedata[CTRL_EN] && !enable;
    case (ctl_address)
      ADDR_CTRL:   rd_c = 32'(ctrl);
      ADDR_MASK:   rd_c = 32'(mask);
      ADDR_OVR:    rd_c = 32'(ovr_cnt);
      ADDR_SEQ:    rd_c = 32'(seq);
      ADDR_STATUS: rd_c = 32'({sticky, (state != ST_IDLE)});
      default:     rd_c = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl         <= '0;
      mask         <= '1;
      ovr_cnt      <= '0;
      sticky       <= 1'b0;
      seq          <= '0;
      ctl_readdata <= '0;
    end else begin
      if (ctl_write && (ctl_address == ADDR_CTRL)) ctrl <= ctl_writedata[2:0];
      if (ctl_write && (ctl_address == ADDR_MASK)) mask <= ctl_writedata[NUM_CH-1:0];
      if (ctl_write && (ctl_address == ADDR_OVR)) begin
        ovr_cnt <= CNT_W'(ovr_n_c);
        sticky  <= |ovr_hit_c;
      end else if (|ovr_hit_c) begin
        ovr_cnt <= ovr_sat_c;
        sticky  <= 1'b1;
      end
      if (seq_clr_c)   seq <= '0;
      else if (last_c) seq <= seq + 16'd1;
      if (ctl_read) ctl_readdata <= rd_c;
    end
  end

endmodule
